// File: rtl/stack_pkg.sv
// Shared encodings and default limits for the stack sequencer.
package stack_pkg;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_INT  = 3'd4;
    localparam logic [2:0] OP_RTI  = 3'd5;

    localparam logic SP_DEC = 1'b0;
    localparam logic SP_INC = 1'b1;

    localparam logic [7:0] STACK_TOP_DEF   = 8'hFE;
    localparam logic [7:0] STACK_LIMIT_DEF = 8'h80;
    localparam logic [7:0] INT_VECTOR_DEF  = 8'h02;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StPushWr,
        StPopInc,
        StPopRd,
        StFinish,
        StDone
    } state_e;

    function automatic logic is_push_op(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
    endfunction

    function automatic logic is_pop_op(input logic [2:0] op);
        return (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
    endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Multi-cycle sequencer for PUSH/POP/CALL/RET/INT/RTI: drives SP strobes, the data-memory
// port, POP writeback and PC/flag load strobes.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter logic [7:0] STACK_TOP   = STACK_TOP_DEF,
    parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF,
    parameter logic [7:0] INT_VECTOR  = INT_VECTOR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] push_data,
    input  logic [1:0] pop_dest,
    input  logic [7:0] ret_pc,
    input  logic [7:0] call_target,
    input  logic [3:0] flags_in,
    input  logic [7:0] raw_sp,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       sp_en,
    output logic       sp_op,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    output logic       rf_wr_en,
    output logic [1:0] rf_wr_addr,
    output logic [7:0] rf_wr_data,
    output logic       pc_load,
    output logic [7:0] pc_value,
    output logic       flags_load,
    output logic [3:0] flags_value
);

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] push_data_q, push_data_d;
    logic [1:0] pop_dest_q, pop_dest_d;
    logic [7:0] ret_pc_q, ret_pc_d;
    logic [7:0] call_target_q, call_target_d;
    logic [3:0] flags_in_q, flags_in_d;
    logic       second_q, second_d;
    logic       err_q, err_d;
    logic [7:0] pop_val_q, pop_val_d;
    logic [3:0] pop_flags_q, pop_flags_d;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        push_data_d   = push_data_q;
        pop_dest_d    = pop_dest_q;
        ret_pc_d      = ret_pc_q;
        call_target_d = call_target_q;
        flags_in_d    = flags_in_q;
        second_d      = second_q;
        err_d         = err_q;
        pop_val_d     = pop_val_q;
        pop_flags_d   = pop_flags_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d          = op;
                    push_data_d   = push_data;
                    pop_dest_d    = pop_dest;
                    ret_pc_d      = ret_pc;
                    call_target_d = call_target;
                    flags_in_d    = flags_in;
                    second_d      = 1'b0;
                    err_d         = 1'b0;
                    state_d       = StCheck;
                end
            end
            StCheck: begin
                // Errors still pass through FINISH (with no strobes) before DONE.
                if ((is_push_op(op_q) && raw_sp == STACK_LIMIT) ||
                    (is_pop_op(op_q) && raw_sp == STACK_TOP) ||
                    (!is_push_op(op_q) && !is_pop_op(op_q))) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else if (is_push_op(op_q)) begin
                    state_d = StPushWr;
                end else begin
                    state_d = StPopInc;
                end
            end
            StPushWr: begin
                if (mem_ready) begin
                    if (op_q == OP_INT && !second_q) begin
                        second_d = 1'b1;
                        state_d  = StCheck;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StPopInc: state_d = StPopRd;
            StPopRd: begin
                if (mem_ready) begin
                    if (op_q == OP_RTI && !second_q) begin
                        pop_flags_d = mem_rdata[3:0];
                        second_d    = 1'b1;
                        state_d     = StCheck;
                    end else begin
                        pop_val_d = mem_rdata;
                        state_d   = StFinish;
                    end
                end
            end
            StFinish: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q != StIdle);
        done        = 1'b0;
        err         = 1'b0;
        sp_en       = 1'b0;
        sp_op       = SP_DEC;
        mem_addr    = 8'h00;
        mem_wdata   = 8'h00;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        rf_wr_en    = 1'b0;
        rf_wr_addr  = 2'd0;
        rf_wr_data  = 8'h00;
        pc_load     = 1'b0;
        pc_value    = 8'h00;
        flags_load  = 1'b0;
        flags_value = 4'h0;
        case (state_q)
            StPushWr: begin
                mem_we   = 1'b1;
                mem_addr = raw_sp;
                if (op_q == OP_PUSH) begin
                    mem_wdata = push_data_q;
                end else if (second_q) begin
                    mem_wdata = {4'h0, flags_in_q};
                end else begin
                    mem_wdata = ret_pc_q;
                end
                // SP decrements on the same edge that completes the write.
                sp_en = mem_ready;
                sp_op = SP_DEC;
            end
            StPopInc: begin
                sp_en = 1'b1;
                sp_op = SP_INC;
            end
            StPopRd: begin
                mem_re   = 1'b1;
                mem_addr = raw_sp;
            end
            StFinish: begin
                if (!err_q) begin
                    case (op_q)
                        OP_POP: begin
                            rf_wr_en   = 1'b1;
                            rf_wr_addr = pop_dest_q;
                            rf_wr_data = pop_val_q;
                        end
                        OP_CALL: begin
                            pc_load  = 1'b1;
                            pc_value = call_target_q;
                        end
                        OP_INT: begin
                            pc_load  = 1'b1;
                            pc_value = INT_VECTOR;
                        end
                        OP_RET: begin
                            pc_load  = 1'b1;
                            pc_value = pop_val_q;
                        end
                        OP_RTI: begin
                            pc_load     = 1'b1;
                            pc_value    = pop_val_q;
                            flags_load  = 1'b1;
                            flags_value = pop_flags_q;
                        end
                        default: ;
                    endcase
                end
            end
            StDone: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            op_q          <= 3'd0;
            push_data_q   <= 8'h00;
            pop_dest_q    <= 2'd0;
            ret_pc_q      <= 8'h00;
            call_target_q <= 8'h00;
            flags_in_q    <= 4'h0;
            second_q      <= 1'b0;
            err_q         <= 1'b0;
            pop_val_q     <= 8'h00;
            pop_flags_q   <= 4'h0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            push_data_q   <= push_data_d;
            pop_dest_q    <= pop_dest_d;
            ret_pc_q      <= ret_pc_d;
            call_target_q <= call_target_d;
            flags_in_q    <= flags_in_d;
            second_q      <= second_d;
            err_q         <= err_d;
            pop_val_q     <= pop_val_d;
            pop_flags_q   <= pop_flags_d;
        end
    end

endmodule
